mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single cache port between two requesters: port 0 (instruction fetch) and port 1 (accumulator data load/store).
- Arbitrates round-robin and issues one cache access at a time (enab/rw/addr/data).
- Waits for the cache to finish a hit or a miss/fill, then returns read data and a done pulse to the granted requester.
- Sits between the processor control unit and the cache.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- TIMEOUT, 64, maximum number of WAIT cycles before the access is aborted with err.

Ports:
- clk  input  1  system clock; all logic on posedge.
- clr  input  1  reset, synchronous, active-high.
- req0, req1  input  1 each  access request per port; held until that port's done.
- rw0, rw1  input  1 each  1=write, 0=read.
- addr0, addr1  input  ADDR_W each  access address.
- wdata0, wdata1  input  DATA_W each  write data.
- done0, done1  output  1 each  one-cycle completion pulse.
- err  output  1  one-cycle pulse, coincident with done, on timeout.
- rdata  output  DATA_W  read data; valid when done0 or done1 is high.
- cache_enab  output  1  one-cycle access strobe to the cache.
- cache_rw  output  1  access type to the cache.
- cache_addr  output  ADDR_W  address to the cache.
- cache_data  output  DATA_W  write data to the cache.
- cache_dout  input  DATA_W  cache read data.
- cache_done  input  1  cache has completed the access (hit or fill finished).
- cache_hit  input  1  sampled together with cache_done.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant=1, so port 0 wins the first tie.
- Reset mid-access drops the transaction: no done pulse, cache_enab low next cycle.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, select the winner and latch its rw/addr/wdata into hold registers; go to ISSUE.
  - Only one requester: it wins.
  - Both requesters: the port != last_grant wins; update last_grant.
- ISSUE:
  - cache_enab=1 for exactly one cycle; cache_rw/addr/data driven from the hold registers.
  - Those outputs stay stable until leaving WAIT.
  - Go to WAIT.
- WAIT:
  - Count cycles from 1.
  - cache_done=1 → capture cache_dout into rdata (reads only; writes leave rdata unchanged) → RESP.
  - Counter reaches TIMEOUT without cache_done → RESP with err pending; rdata unchanged.
  - cache_done arriving in the same cycle as the limit is reached counts as success.
- RESP:
  - doneN=1 for the granted port only; err=1 if pending.
  - Next state IDLE, so a back-to-back request is sampled in the following cycle.
- Minimum latency: req sampled in cycle N → cache_enab in N+1 → done in N+3 when cache_done is high in N+2.
- Request handling:
  - Requests in non-IDLE states are not sampled.
  - A port dropping req mid-transaction does not cancel it; done still pulses.
  - A loser keeping req high is granted in the next IDLE, so there is no starvation.
- Hold registers capture inputs only in IDLE, so changes on addr/wdata after the grant are ignored.
- The timeout counter is ceil(log2(TIMEOUT+1)) bits wide and saturates; it clears on entry to WAIT.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Enabled:
  - Adds outputs hit_cnt, miss_cnt, wait_cnt (16 bits each).
  - hit_cnt / miss_cnt increment on successful completion, per cache_hit.
  - wait_cnt increments every cycle where a req is high but not granted.
  - All counters saturate at 16'hFFFF and clear on clr.
- Disabled: no ports and no logic for the counters; behaviour otherwise identical.

Decomposition:
- Shared package holds the FSM state encoding constants: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3.
- Package also holds default widths ADDR_W/DATA_W, shared with the cache and the control unit.
- One sub-module: mem_arb_rr, the combinational-plus-last_grant round-robin picker. Inputs req0/req1/last_grant; outputs winner and grant_valid.

Test Plan:
- Reset: assert clr for 2 cycles during WAIT → next cycle cache_enab=0, busy=0, no done; then a single req0 is granted first.
- Single read hit: req0 read addr 8'h01; cache_done=1, cache_dout=8'hE0 on the 2nd cycle after the req → rdata=8'hE0 with done0 on the 3rd cycle; cache_enab high for exactly 1 cycle.
- Tie: req0 and req1 asserted together after reset → port 0 served first, then port 1. Repeat the tie → grant order alternates 0,1,0,1.
- Miss: req1 write addr 8'h04 data 8'h18; cache_done delayed 10 cycles → cache_addr=8'h04 and cache_data=8'h18 stable throughout WAIT; done1 1 cycle after cache_done; rdata unchanged.
- Timeout: TIMEOUT=64, cache_done never asserted → done0 and err pulse together 64 WAIT cycles after ISSUE; FSM returns to IDLE.
- Stats (MEM_ARB_STATS_EN): 3 hits plus 1 miss → hit_cnt=3, miss_cnt=1. wait_cnt equals the cycles the losing port spent requesting without a grant.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state encoding and default widths for the cache-port arbiter
package mem_arbiter_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - two-port round-robin picker driven by the last granted port
module mem_arb_rr (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic winner,
    output logic grant_valid
);

    always_comb begin
        grant_valid = req0 | req1;
        winner      = 1'b0;
        if (req0 && req1) begin
            winner = ~last_grant;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one cache port between fetch and data ports
// Optional access statistics counters: define MEM_ARB_STATS_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req0,
    input  logic              req1,
    input  logic              rw0,
    input  logic              rw1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              cache_enab,
    output logic              cache_rw,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [DATA_W-1:0] cache_data,
    input  logic [DATA_W-1:0] cache_dout,
    input  logic              cache_done,
    input  logic              cache_hit,
    output logic              busy
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt,
    output logic [15:0]       wait_cnt
`endif
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              last_grant;
    logic              grant_port;
    logic              err_pend;
    logic              hold_rw;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_wdata;
    logic [CNT_W-1:0]  wait_ctr;
    logic [CNT_W-1:0]  ctr_inc;
    logic              wait_limit;
    logic              winner;
    logic              grant_valid;

    mem_arb_rr u_rr (
        .req0        (req0),
        .req1        (req1),
        .last_grant  (last_grant),
        .winner      (winner),
        .grant_valid (grant_valid)
    );

    // ctr_inc is the 1-based number of the current WAIT cycle
    assign ctr_inc    = (wait_ctr == {CNT_W{1'b1}}) ? wait_ctr : wait_ctr + CNT_W'(1);
    assign wait_limit = (ctr_inc == CNT_W'(TIMEOUT));

    assign cache_rw   = hold_rw;
    assign cache_addr = hold_addr;
    assign cache_data = hold_wdata;

    always_comb begin
        state_nxt  = state;
        cache_enab = 1'b0;
        done0      = 1'b0;
        done1      = 1'b0;
        err        = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant_valid) state_nxt = ISSUE;
            end
            ISSUE: begin
                cache_enab = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                if (cache_done || wait_limit) state_nxt = RESP;
            end
            RESP: begin
                done0     = ~grant_port;
                done1     = grant_port;
                err       = err_pend;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_port <= 1'b0;
            err_pend   <= 1'b0;
            hold_rw    <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            wait_ctr   <= '0;
            rdata      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        grant_port <= winner;
                        last_grant <= winner;
                        err_pend   <= 1'b0;
                        hold_rw    <= winner ? rw1 : rw0;
                        hold_addr  <= winner ? addr1 : addr0;
                        hold_wdata <= winner ? wdata1 : wdata0;
                    end
                end
                ISSUE: wait_ctr <= '0;
                WAIT: begin
                    wait_ctr <= ctr_inc;
                    // a completion on the limit cycle still counts as success
                    if (cache_done) begin
                        if (!hold_rw) rdata <= cache_dout;
                    end else if (wait_limit) begin
                        err_pend <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic own0;
    logic own1;
    logic req_waiting;

    // in IDLE the picker's winner counts as granted in the same cycle
    assign own0        = (state == IDLE) ? (grant_valid && !winner) : !grant_port;
    assign own1        = (state == IDLE) ? (grant_valid && winner) : grant_port;
    assign req_waiting = (req0 && !own0) || (req1 && !own1);

    always_ff @(posedge clk) begin
        if (clr) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            if (state == WAIT && cache_done) begin
                if (cache_hit && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
                if (!cache_hit && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            end
            if (req_waiting && wait_cnt != 16'hFFFF) wait_cnt <= wait_cnt + 16'd1;
        end
    end
`else
    logic stats_unused;
    assign stats_unused = cache_hit;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       clr;
    logic       req0, req1, rw0, rw1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       done0, done1, err;
    logic [7:0] rdata;
    logic       cache_enab, cache_rw;
    logic [7:0] cache_addr, cache_data, cache_dout;
    logic       cache_done, cache_hit, busy;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] hit_cnt, miss_cnt, wait_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk        (clk),
        .clr        (clr),
        .req0       (req0),
        .req1       (req1),
        .rw0        (rw0),
        .rw1        (rw1),
        .addr0      (addr0),
        .addr1      (addr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .done0      (done0),
        .done1      (done1),
        .err        (err),
        .rdata      (rdata),
        .cache_enab (cache_enab),
        .cache_rw   (cache_rw),
        .cache_addr (cache_addr),
        .cache_data (cache_data),
        .cache_dout (cache_dout),
        .cache_done (cache_done),
        .cache_hit  (cache_hit),
        .busy       (busy)
`ifdef MEM_ARB_STATS_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt),
        .wait_cnt   (wait_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic p, input logic rw, input logic [7:0] a, input logic [7:0] wd);
        if (p) begin
            req1 = 1'b1; rw1 = rw; addr1 = a; wdata1 = wd;
        end else begin
            req0 = 1'b1; rw0 = rw; addr0 = a; wdata0 = wd;
        end
    endtask

    // Called in an IDLE cycle with requests already set; returns in the following IDLE cycle.
    task automatic run_txn(input logic p, input logic rw, input logic [7:0] a, input logic [7:0] wd,
                           input int dly, input logic [7:0] dout, input logic hit,
                           input logic [7:0] exp_rd);
        tick;
        check_eq("issue_enab", cache_enab, 1);
        check_eq("issue_rw", cache_rw, rw);
        check_eq("issue_addr", cache_addr, a);
        if (rw) check_eq("issue_data", cache_data, wd);
        if (p) begin addr1 = ~a; wdata1 = ~wd; end
        else   begin addr0 = ~a; wdata0 = ~wd; end
        for (int i = 1; i <= dly; i++) begin
            tick;
            check_eq("wait_enab", cache_enab, 0);
            check_eq("wait_addr", cache_addr, a);
            if (rw) check_eq("wait_data", cache_data, wd);
            check_eq("wait_done", {done1, done0}, 0);
            if (i == dly) begin
                cache_done = 1'b1; cache_dout = dout; cache_hit = hit;
            end
        end
        tick;
        cache_done = 1'b0; cache_hit = 1'b0; cache_dout = 8'h00;
        check_eq("resp_done", {done1, done0}, p ? 2'b10 : 2'b01);
        check_eq("resp_err", err, 0);
        check_eq("resp_rdata", rdata, exp_rd);
        check_eq("resp_enab", cache_enab, 0);
        if (p) req1 = 1'b0; else req0 = 1'b0;
        tick;
        check_eq("idle_busy", busy, 0);
        check_eq("idle_done", {done1, done0}, 0);
    endtask

    initial begin
        clr = 1'b1;
        req0 = 0; req1 = 0; rw0 = 0; rw1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        cache_dout = 0; cache_done = 0; cache_hit = 0;
        tick; tick;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_enab", cache_enab, 0);
        check_eq("rst_done", {err, done1, done0}, 0);
        check_eq("rst_rdata", rdata, 0);
        check_eq("rst_cache_bus", {cache_rw, cache_addr, cache_data}, 0);
        clr = 1'b0;

        // reset in the middle of WAIT drops the access
        set_req(0, 0, 8'h10, 8'h00);
        tick;
        check_eq("mid_issue", cache_enab, 1);
        tick;
        check_eq("mid_wait_busy", busy, 1);
        clr = 1'b1; req0 = 1'b0;
        tick;
        check_eq("mid_rst_enab", cache_enab, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_done", {done1, done0}, 0);
        tick;
        clr = 1'b0;
        check_eq("mid_rst_done2", {done1, done0}, 0);

        // single read hit at minimum latency
        set_req(0, 0, 8'h01, 8'h00);
        run_txn(0, 0, 8'h01, 8'h00, 1, 8'hE0, 1, 8'hE0);

        // ties after reset alternate 0,1,0,1
        clr = 1'b1;
        tick;
        clr = 1'b0;
        check_eq("clr_rdata", rdata, 0);
        set_req(0, 0, 8'h20, 8'h00);
        set_req(1, 0, 8'h21, 8'h00);
        run_txn(0, 0, 8'h20, 8'h00, 1, 8'hA5, 1, 8'hA5);
        run_txn(1, 0, 8'h21, 8'h00, 1, 8'h5A, 1, 8'h5A);
        set_req(0, 1, 8'h22, 8'h11);
        set_req(1, 0, 8'h23, 8'h00);
        run_txn(0, 1, 8'h22, 8'h11, 2, 8'hFF, 1, 8'h5A);
        run_txn(1, 0, 8'h23, 8'h00, 3, 8'h3C, 1, 8'h3C);

        // write miss with a 10-cycle fill; rdata untouched
        set_req(1, 1, 8'h04, 8'h18);
        run_txn(1, 1, 8'h04, 8'h18, 10, 8'h77, 0, 8'h3C);

        // completion on the very last allowed WAIT cycle is a success
        set_req(0, 0, 8'h40, 8'h00);
        run_txn(0, 0, 8'h40, 8'h00, 64, 8'h9C, 1, 8'h9C);

        // timeout: no cache_done at all
        set_req(0, 0, 8'h50, 8'h00);
        tick;
        check_eq("to_issue", cache_enab, 1);
        for (int i = 1; i <= 64; i++) begin
            tick;
            check_eq("to_wait_done", {err, done1, done0}, 0);
        end
        tick;
        check_eq("to_done", {done1, done0}, 2'b01);
        check_eq("to_err", err, 1);
        check_eq("to_rdata", rdata, 8'h9C);
        req0 = 1'b0;
        tick;
        check_eq("to_idle_busy", busy, 0);
        check_eq("to_idle_err", err, 0);

        // back-to-back access after a timeout clears the error
        set_req(1, 0, 8'h60, 8'h00);
        run_txn(1, 0, 8'h60, 8'h00, 1, 8'h42, 1, 8'h42);

`ifdef MEM_ARB_STATS_EN
        check_eq("stat_hit", hit_cnt, 16'd6);
        check_eq("stat_miss", miss_cnt, 16'd1);
        check_eq("stat_wait", wait_cnt, 16'd9);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
